// File: rtl/eth_pcs_rx_descrambler_pkg.sv
// Shared widths, scrambler polynomial taps and sync-header encodings for the PCS receive path.
package eth_pcs_params;

  localparam int W_DATA  = 32;
  localparam int W_SYNC  = 2;
  localparam int W_BLK   = 64;
  localparam int SCR_LEN = 58;
  localparam int SCR_TAP = 39;

  localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
  localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;

  function automatic logic hdr_invalid(input logic [W_SYNC-1:0] hdr);
    return !((hdr == SYNC_DATA) || (hdr == SYNC_CTRL));
  endfunction

endpackage

// File: rtl/eth_pcs_rx_descrambler_word.sv
// Combinational x^58+x^39+1 self-synchronous descrambler for one payload word.
// Zero latency; no flow control (pure function of state and word).
module eth_pcs_descramble_word
  import eth_pcs_params::*;
(
  input  logic [SCR_LEN-1:0] i_state,
  input  logic [W_DATA-1:0]  i_word,
  output logic [W_DATA-1:0]  o_word,
  output logic [SCR_LEN-1:0] o_state
);

  // Concatenated stream: bit SCR_LEN+i is the current bit i, lower bits are history.
  logic [SCR_LEN+W_DATA-1:0] w_ext;

  assign w_ext = {i_word, i_state};

  always_comb begin
    o_word = '0;
    for (int i = 0; i < W_DATA; i++) begin
      o_word[i] = w_ext[SCR_LEN+i] ^ w_ext[SCR_LEN-SCR_TAP+i] ^ w_ext[i];
    end
  end

  assign o_state = w_ext[SCR_LEN+W_DATA-1 -: SCR_LEN];

endmodule

// File: rtl/eth_pcs_rx_descrambler.sv
// Descrambles RX payload words and reassembles 66-bit blocks; strobe 1 cycle after word 1.
// No backpressure: every accepted word advances the scrambler state.
module eth_pcs_rx_descrambler
  import eth_pcs_params::*;
#(
  parameter bit DESCRAMBLE_BYPASS = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx_lock,
  input  logic              i_hdr_valid,
  input  logic [W_SYNC-1:0] i_hdr,
  input  logic              i_data_valid,
  input  logic [W_DATA-1:0] i_data,
  output logic              o_blk_valid,
  output logic [W_SYNC-1:0] o_blk_hdr,
  output logic [W_BLK-1:0]  o_blk_data,
  output logic              o_hdr_err,
  output logic              o_align_err
);

  logic [SCR_LEN-1:0] r_s;
  logic [W_SYNC-1:0]  r_hdr;
  logic               r_hdr_lat;
  logic [1:0]         r_wcnt;
  logic [W_DATA-1:0]  r_word0;
  logic               r_blk_valid;
  logic [W_SYNC-1:0]  r_blk_hdr;
  logic [W_BLK-1:0]   r_blk_data;
  logic               r_hdr_err;
  logic               r_align_err;

  logic [W_DATA-1:0]  w_descr;
  logic [SCR_LEN-1:0] w_next_s;
  logic [W_DATA-1:0]  w_word;
  logic               w_wd1;
  logic               w_emit;
  logic               w_misalign;

  eth_pcs_descramble_word u_descr (
    .i_state (r_s),
    .i_word  (i_data),
    .o_word  (w_descr),
    .o_state (w_next_s)
  );

  assign w_word     = DESCRAMBLE_BYPASS ? i_data : w_descr;
  assign w_wd1      = i_data_valid && r_hdr_lat && (r_wcnt == 2'd1);
  assign w_emit     = i_rx_lock && w_wd1;
  // A header landing with word 1 closes the old block cleanly; only a header on an idle slot mid-block is an error.
  assign w_misalign = i_rx_lock && i_hdr_valid && r_hdr_lat && (r_wcnt == 2'd1) && !i_data_valid;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s         <= '0;
      r_hdr       <= '0;
      r_hdr_lat   <= 1'b0;
      r_wcnt      <= 2'd0;
      r_word0     <= '0;
      r_blk_valid <= 1'b0;
      r_blk_hdr   <= '0;
      r_blk_data  <= '0;
      r_hdr_err   <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      if (i_data_valid) begin
        r_s <= w_next_s;
      end

      if (!i_rx_lock) begin
        r_hdr_lat <= 1'b0;
        r_wcnt    <= 2'd0;
      end else if (i_hdr_valid) begin
        r_hdr_lat <= 1'b1;
        r_hdr     <= i_hdr;
        if (i_data_valid && !w_wd1) begin
          r_word0 <= w_word;
          r_wcnt  <= 2'd1;
        end else begin
          r_wcnt  <= 2'd0;
        end
      end else if (i_data_valid && r_hdr_lat) begin
        if (r_wcnt == 2'd0) begin
          r_word0 <= w_word;
          r_wcnt  <= 2'd1;
        end else if (r_wcnt == 2'd1) begin
          r_wcnt  <= 2'd2;
        end
      end

      r_blk_valid <= w_emit;
      r_align_err <= w_misalign;
      if (w_emit) begin
        r_blk_hdr  <= r_hdr;
        r_blk_data <= {w_word, r_word0};
        r_hdr_err  <= hdr_invalid(r_hdr);
      end
    end
  end

  assign o_blk_valid = r_blk_valid;
  assign o_blk_hdr   = r_blk_hdr;
  assign o_blk_data  = r_blk_data;
  assign o_hdr_err   = r_hdr_err;
  assign o_align_err = r_align_err;

endmodule

// File: tb/tb_eth_pcs_rx_descrambler.sv
// Randomised scoreboard bench: bit-serial reference descrambler plus golden scrambler, two DUTs (normal and bypass).
module tb_eth_pcs_rx_descrambler;
  import eth_pcs_params::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, lock, hv, dv;
  logic [1:0]  hdr;
  logic [31:0] data;
  logic        lk;

  logic        a_vld, a_herr, a_aerr;
  logic [1:0]  a_hdr;
  logic [63:0] a_dat;
  logic        b_vld, b_herr, b_aerr;
  logic [1:0]  b_hdr;
  logic [63:0] b_dat;

  eth_pcs_rx_descrambler #(.DESCRAMBLE_BYPASS(1'b0)) dut (
    .i_clk(clk), .i_reset(reset), .i_rx_lock(lock), .i_hdr_valid(hv), .i_hdr(hdr),
    .i_data_valid(dv), .i_data(data), .o_blk_valid(a_vld), .o_blk_hdr(a_hdr),
    .o_blk_data(a_dat), .o_hdr_err(a_herr), .o_align_err(a_aerr));

  eth_pcs_rx_descrambler #(.DESCRAMBLE_BYPASS(1'b1)) dut_byp (
    .i_clk(clk), .i_reset(reset), .i_rx_lock(lock), .i_hdr_valid(hv), .i_hdr(hdr),
    .i_data_valid(dv), .i_data(data), .o_blk_valid(b_vld), .o_blk_hdr(b_hdr),
    .o_blk_data(b_dat), .o_hdr_err(b_herr), .o_align_err(b_aerr));

  typedef struct {
    logic [1:0]  hdr;
    logic [63:0] data;
    logic [63:0] raw;
    logic        herr;
    logic        has_plain;
    logic [63:0] plain;
    logic [63:0] due;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] align_q[$];
  bit          hist[$];
  bit          gold[$];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference descrambler: out[n] = in[n] ^ in[n-39] ^ in[n-58], history of received bits.
  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < 58; i++) hist.push_back(1'b0);
  endfunction

  function automatic logic [31:0] model_descr(input logic [31:0] d);
    logic [31:0] o;
    for (int i = 0; i < 32; i++) begin
      o[i] = d[i] ^ hist[hist.size()-39] ^ hist[hist.size()-58];
      hist.push_back(d[i]);
      void'(hist.pop_front());
    end
    return o;
  endfunction

  function automatic logic [31:0] gold_scr(input logic [31:0] p);
    logic [31:0] s;
    for (int i = 0; i < 32; i++) begin
      s[i] = p[i] ^ gold[gold.size()-39] ^ gold[gold.size()-58];
      gold.push_back(s[i]);
      void'(gold.pop_front());
    end
    return s;
  endfunction

  task automatic cyc(input logic h_v, input logic [1:0] h, input logic d_v,
                     input logic [31:0] d, output logic [31:0] dd);
    @(negedge clk);
    hv = h_v; hdr = h; dv = d_v; data = d; lock = lk;
    @(posedge clk);
    dd = d_v ? model_descr(d) : 32'h0;
  endtask

  task automatic idle();
    logic [31:0] dmy;
    cyc(1'b0, 2'b00, 1'b0, 32'h0, dmy);
  endtask

  task automatic gaps();
    repeat ($urandom_range(0, 2)) idle();
  endtask

  // Called right after the posedge that accepts word 1; strobe is visible at the next negedge.
  task automatic push_blk(input logic [1:0] h, input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] r0, input logic [31:0] r1,
                          input logic hp, input logic [63:0] p);
    exp_t e;
    e.hdr = h; e.data = {d1, d0}; e.raw = {r1, r0};
    e.herr = (h == 2'b00) || (h == 2'b11);
    e.has_plain = hp; e.plain = p; e.due = 64'($time) + 64'd5;
    exp_q.push_back(e);
  endtask

  task automatic send_block(input logic [1:0] h, input logic [31:0] w0, input logic [31:0] w1,
                            input logic hp, input logic [63:0] p);
    logic [31:0] d0, d1, dmy;
    if ($urandom_range(0, 1) == 1) begin
      cyc(1'b1, h, 1'b1, w0, d0);
    end else begin
      cyc(1'b1, h, 1'b0, 32'h0, dmy);
      gaps();
      cyc(1'b0, 2'b00, 1'b1, w0, d0);
    end
    gaps();
    cyc(1'b0, 2'b00, 1'b1, w1, d1);
    push_blk(h, d0, d1, w0, w1, hp, p);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (a_vld) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {63'h0, a_vld}, 64'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("strobe_time", 64'($time), e.due);
          chk("blk_hdr", {62'h0, a_hdr}, {62'h0, e.hdr});
          chk("blk_data", a_dat, e.data);
          chk("hdr_err", {63'h0, a_herr}, {63'h0, e.herr});
          if (e.has_plain) chk("plaintext", a_dat, e.plain);
          chk("byp_valid", {63'h0, b_vld}, 64'h1);
          chk("byp_data", b_dat, e.raw);
        end
      end else if (b_vld) begin
        chk("byp_unexpected_strobe", {63'h0, b_vld}, 64'h0);
      end
      if (a_aerr) begin
        if (align_q.size() == 0) chk("unexpected_align_err", {63'h0, a_aerr}, 64'h0);
        else chk("align_time", 64'($time), align_q.pop_front());
      end
      if (b_aerr !== a_aerr) chk("byp_align_err", {63'h0, b_aerr}, {63'h0, a_aerr});
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_vld"}, {63'h0, a_vld}, 64'h0);
    chk({tag, "_aerr"}, {63'h0, a_aerr}, 64'h0);
    chk({tag, "_herr"}, {63'h0, a_herr}, 64'h0);
    chk({tag, "_hdr"}, {62'h0, a_hdr}, 64'h0);
    chk({tag, "_data"}, a_dat, 64'h0);
    chk({tag, "_byp_data"}, b_dat, 64'h0);
  endtask

  initial begin
    logic [31:0] d0, d1, dmy;
    logic [63:0] p;
    logic [1:0]  h;
    int          r;

    reset = 1'b1; lk = 1'b1; lock = 1'b1; hv = 1'b0; dv = 1'b0; hdr = 2'b00; data = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_zero("reset");

    // Known vector
    cyc(1'b1, 2'b01, 1'b1, 32'h0000_0001, d0);
    cyc(1'b0, 2'b00, 1'b1, 32'h0000_0000, d1);
    push_blk(2'b01, 32'h0000_0001, 32'h0400_0080, 32'h1, 32'h0, 1'b1, 64'h0400_0080_0000_0001);
    idle(); idle();

    // Bad headers
    send_block(2'b00, $urandom, $urandom, 1'b0, 64'h0);
    gaps();
    send_block(2'b11, $urandom, $urandom, 1'b0, 64'h0);
    idle();

    // Back-to-back: header with word 1 closes the old block and opens a new one
    cyc(1'b1, 2'b01, 1'b1, 32'hA5A5_0001, d0);
    cyc(1'b1, 2'b10, 1'b1, 32'h5A5A_0002, d1);
    push_blk(2'b01, d0, d1, 32'hA5A5_0001, 32'h5A5A_0002, 1'b0, 64'h0);
    cyc(1'b0, 2'b00, 1'b1, 32'h1234_5678, d0);
    cyc(1'b0, 2'b00, 1'b1, 32'h9ABC_DEF0, d1);
    push_blk(2'b10, d0, d1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 64'h0);
    // Orphan words after a full block
    cyc(1'b0, 2'b00, 1'b1, $urandom, dmy);
    cyc(1'b0, 2'b00, 1'b1, $urandom, dmy);
    idle();

    // Misalignment: header on an idle slot after only word 0
    cyc(1'b1, 2'b01, 1'b1, $urandom, dmy);
    cyc(1'b1, 2'b10, 1'b0, 32'h0, dmy);
    align_q.push_back(64'($time) + 64'd5);
    send_block(2'b10, $urandom, $urandom, 1'b0, 64'h0);
    idle();

    // Lock drop mid-block; state must stay synchronised
    cyc(1'b1, 2'b01, 1'b1, $urandom, dmy);
    lk = 1'b0;
    cyc(1'b0, 2'b00, 1'b1, $urandom, dmy);
    cyc(1'b1, 2'b10, 1'b0, 32'h0, dmy);
    cyc(1'b1, 2'b01, 1'b1, $urandom, dmy);
    cyc(1'b0, 2'b00, 1'b1, $urandom, dmy);
    lk = 1'b1;
    cyc(1'b0, 2'b00, 1'b1, $urandom, dmy);
    send_block(2'b01, $urandom, $urandom, 1'b0, 64'h0);
    idle();

    // Reset between word 0 and word 1
    cyc(1'b1, 2'b10, 1'b1, $urandom, dmy);
    @(negedge clk);
    reset = 1'b1; hv = 1'b0; dv = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_zero("midreset");
    idle(); idle();
    check_zero("postreset");
    send_block(2'b01, $urandom, $urandom, 1'b0, 64'h0);

    // Golden-scrambler stream with random seed and gaps
    gold.delete();
    for (int i = 0; i < 58; i++) gold.push_back(1'($urandom_range(0, 1)));
    for (int b = 0; b < 1000; b++) begin
      p = {$urandom, $urandom};
      r = $urandom_range(0, 19);
      h = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 10) ? SYNC_DATA : SYNC_CTRL;
      d0 = gold_scr(p[31:0]);
      d1 = gold_scr(p[63:32]);
      send_block(h, d0, d1, (b > 0), p);
      gaps();
    end

    repeat (5) idle();
    chk("leftover_blocks", 64'(exp_q.size()), 64'h0);
    chk("leftover_align", 64'(align_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eth_pcs_rx_descrambler.md
# eth_pcs_rx_descrambler

Receive-path stage directly downstream of the RX gearbox. Accepts sync headers and 32-bit scrambled payload words, removes the self-synchronous x^58+x^39+1 scrambling, and reassembles full 66-bit blocks (2-bit header plus 64-bit payload) for the 64b/66b decoder. It gates output on block lock, flags invalid sync headers, and detects header/payload misalignment.

## Interface
- `W_DATA`, default 32 (package): width of an input payload word.
- `W_SYNC`, default 2 (package): sync header width.
- `W_BLK`, default 64 (package): payload bits per block; must equal 2*W_DATA.
- `DESCRAMBLE_BYPASS`, default 0: when 1, payload passes through unscrambled; the state register still updates.

Ports:
- `i_clk`  in  1  single clock.
- `i_reset`  in  1  synchronous reset, active-high.
- `i_rx_lock`  in  1  block lock from the block-sync stage.
- `i_hdr_valid`  in  1  `i_hdr` carries the header of a new block this cycle.
- `i_hdr`  in  W_SYNC  sync header, bit 0 received first.
- `i_data_valid`  in  1  `i_data` carries a payload word this cycle.
- `i_data`  in  W_DATA  scrambled payload word, bit 0 received first.
- `o_blk_valid`  out  1  single-cycle strobe: block outputs are valid.
- `o_blk_hdr`  out  W_SYNC  header of the emitted block.
- `o_blk_data`  out  W_BLK  descrambled payload; [31:0] is word 0.
- `o_hdr_err`  out  1  valid with `o_blk_valid`; header is 2'b00 or 2'b11.
- `o_align_err`  out  1  single-cycle pulse: a partial block was dropped.

## Operation
- **Scrambler state:** a 58-bit register `s` holds the last 58 scrambled bits received, with the newest bit at the MSB end. It is updated on every accepted word, regardless of lock or block state.
- **Descramble rule:** for stream bit n, out[n] = in[n] ^ in[n-39] ^ in[n-58]. The word is computed in parallel: bit i uses `s` for history and `i_data` bits below i. The new state is `{i_data, s}` truncated to the top 58 bits.
- **Word counter:** `wcnt` is 2 bits, taking values 0, 1 and 2 = full.
  - On `i_hdr_valid`, `i_hdr` is latched into the header register and `wcnt` restarts.
  - A data word in the same cycle as `i_hdr_valid` is word 0 of the new block.
- **Misalignment:** `i_hdr_valid` while `wcnt`==1 drops the partial block and pulses `o_align_err` on the next cycle.
- **Orphan words:** words arriving with no header latched, or after 2 words have already been collected, are descrambled for state only and discarded.
- **Block emission:** on acceptance of word 1, the block is emitted.
- **Lock gating:** `i_rx_lock`=0 forces the header-latched flag and `wcnt` to clear. No blocks are emitted and `o_align_err` is suppressed. `s` keeps updating.
- **Gaps:** `i_data_valid` gaps, such as the gearbox's empty slip cycle, are tolerated at any point; the counters simply hold.

## Timing
- **Reset values:** `o_blk_valid`=0, `o_align_err`=0, `o_hdr_err`=0, `o_blk_hdr`=0, `o_blk_data`=0, `s`=0, `wcnt`=0, header-latched flag=0.
- **Latency:** `o_blk_valid` rises 1 cycle after the cycle that accepts word 1. Block outputs hold until the next emission.
- **Back-to-back blocks:** `i_hdr_valid` in the same cycle that word 1 is accepted completes the old block and opens a new one. No error is raised.
- **Throughput:** `o_blk_valid` pulses at most once every 2 cycles. There is no backpressure.
- **Reset mid-block:** the partial block is discarded and no strobe is produced.

## Structure
- **Package additions (`eth_pcs_params`):** `W_BLK`, `SCR_LEN`=58, `SCR_TAP`=39, plus the header encodings `SYNC_DATA`=2'b01 and `SYNC_CTRL`=2'b10.
- **Sub-module `eth_pcs_descramble_word`:** a purely combinational W_DATA-wide descrambler taking (state, word) and returning (out, next state). It is reused later for the TX scrambler check.
- **Top module:** owns the assembler, counters and output registers.

## Test plan
- **Known vector:** after reset with lock=1, send hdr 2'b01, word 32'h0000_0001, then word 32'h0 → `o_blk_data`=64'h0400_0080_0000_0001, `o_blk_hdr`=2'b01, `o_hdr_err`=0, one strobe.
- **Golden-scrambler stream:** drive 1000 random blocks from a golden scrambler with random seed and random `i_data_valid` gaps → after the first block, every emitted block matches the original plaintext.
- **Bad headers:** blocks with hdr 2'b00 and 2'b11 → `o_hdr_err`=1 on the corresponding strobe, payload still correct.
- **Misalignment:** `i_hdr_valid` after only word 0 → `o_align_err` pulses once, no strobe for the partial block, and the next complete block emits correctly.
- **Lock drop:** lock goes low mid-block → no strobe and no `o_align_err`; after relock plus header, the block is correct because the state stayed synchronised.
- **Bypass and reset:** with `DESCRAMBLE_BYPASS`=1, `o_blk_data` equals the raw input words. A reset between word 0 and word 1 produces no strobe and all outputs read 0.
